instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit that drives the program-counter address into the instruction memory and captures the returned 8-bit instruction for the decode stage. It holds the PC, steps it by 2 per fetched instruction, and presents each instruction with its PC through a valid/ready handshake. It also applies jump redirects with a flush, and supports a sticky halt. It sits between the instruction memory (combinational read) and the decoder/control unit.

## Interface
- ADDR_WIDTH, 8, width of PC and memory address
- INSTR_WIDTH, 8, instruction width
- PC_STEP, 2, PC increment per fetched instruction
- RESET_PC, 8'h00, PC value after reset

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_address  output  ADDR_WIDTH  address to instruction memory; equals internal PC register
- mem_instr  input  INSTR_WIDTH  instruction returned combinationally by memory for pc_address
- instr_out  output  INSTR_WIDTH  captured instruction to decode
- instr_pc  output  ADDR_WIDTH  address instr_out was fetched from
- instr_valid  output  1  instr_out/instr_pc hold a valid instruction
- instr_ready  input  1  decode accepts instruction this cycle
- jump_valid  input  1  redirect request; single-cycle pulse
- jump_target  input  ADDR_WIDTH  redirect address; bit 0 forced to 0
- halt  input  1  stop fetching; sticky until jump_valid or reset
- halted  output  1  unit is in HALTED state
- fetch_count  output  16  instructions captured since reset; saturates at 16'hFFFF

## Operation
- Reset (synchronous, reset=1 at edge): PC=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, state=FETCH. Reset overrides every other input.
- States: FETCH and HALTED.
- The output register is "free" when instr_valid=0 or (instr_valid=1 and instr_ready=1).
- FETCH, priority order per edge:
  1. jump_valid=1: PC←{jump_target[7:1],0}; instr_valid←0 (flush, even if instr_ready=1); no capture. If halt=1 same cycle, next state is HALTED; else stays FETCH.
  2. halt=1: no capture; PC unchanged; instr_valid cleared only if accepted this cycle (valid and ready), otherwise held; next state HALTED.
  3. Output register free: instr_out←mem_instr, instr_pc←PC, instr_valid←1, PC←PC+PC_STEP (mod 2^ADDR_WIDTH), fetch_count+1 saturating.
  4. Otherwise (stall, instr_valid=1 and instr_ready=0): all outputs and PC held.
- HALTED: no capture; PC frozen. The pending instruction stays valid until accepted, then instr_valid←0. jump_valid=1 → PC←target, instr_valid←0, state FETCH. halt has no effect in HALTED.
- halted=1 exactly when state=HALTED.
- Wrap-around: PC 8'hFE + 2 → 8'h00, with no flag.
- instr_out and instr_pc are stable while instr_valid=1 and instr_ready=0.

## Timing
- pc_address is registered. mem_instr is sampled at the same edge that advances PC.
- Fetch latency: instruction at address A appears on instr_out one edge after pc_address=A.
- Throughput: one instruction per cycle while instr_ready=1.
- First edge after reset release: instr_valid=1, instr_pc=RESET_PC.
- Jump: the edge with jump_valid=1 gives pc_address=target and instr_valid=0. The next edge gives instr_out=mem[target], instr_pc=target. Redirect bubble is 1 cycle.
- halt sampled at edge N: halted=1 after edge N. No new capture occurs at edge N or later.
- Reset asserted mid-stall or mid-jump: all state returns to reset values at that edge. The pending instruction is discarded.

## Test plan
- Sequential fetch, memory program {00:00, 02:D3, 04:50, 06:D1, 08:51, 0A:10}, instr_ready=1 → instr_out sequence 00,D3,50,D1,51,10 on consecutive cycles. instr_pc 00,02,04,06,08,0A. fetch_count=6.
- Backpressure: instr_ready=0 for 3 cycles while instr_out=D3 → instr_out=D3, instr_pc=02, pc_address=04 held. Release → next accepted instr is 50 at 04, with no duplicate or skip.
- Jump: at instr_pc=04, pulse jump_valid with jump_target=8'h09 → one cycle instr_valid=0, then instr_out=51, instr_pc=08, then 10 at 0A.
- Halt then resume: halt at pc_address=06 → halted=1, pc_address stays 06, instr_valid drops after acceptance. jump_valid with target 00 → halted=0, instr_out=00 at 00.
- Wrap: jump to FE, ready=1 → instr_pc FE then 00. pc_address goes FE→00→02.
- Simultaneous and reset: jump_valid+halt same edge, target 0A → halted=1, pc_address=0A, instr_valid=0. Then reset=1 mid-stall → pc_address=00, instr_valid=0, halted=0, fetch_count=0 after that edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Holds the program counter, drives it to an instruction memory with a
// combinational read port, and captures the returned instruction into an
// output register presented to the decoder through a valid/ready handshake.
// Supports jump redirects (with a one-cycle flush bubble) and a sticky halt
// that is released only by a jump or by reset.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   pc_address   current PC, drives the instruction memory address
//   mem_instr    instruction read combinationally from memory at pc_address
//   instr_out    captured instruction for decode
//   instr_pc     address that instr_out was fetched from
//   instr_valid  instr_out / instr_pc hold a valid instruction
//   instr_ready  decode accepts the presented instruction this cycle
//   jump_valid   single-cycle redirect request
//   jump_target  redirect address (bit 0 ignored, forced to 0)
//   halt         stop fetching; sticky until jump_valid or reset
//   halted       unit is in the HALTED state
//   fetch_count  number of instructions captured since reset, saturating
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    INSTR_WIDTH = 8,
   parameter int                    PC_STEP     = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 8'h00
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [ADDR_WIDTH-1:0]  pc_address,
   input  logic [INSTR_WIDTH-1:0] mem_instr,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   jump_valid,
   input  logic [ADDR_WIDTH-1:0]  jump_target,
   input  logic                   halt,
   output logic                   halted,
   output logic [15:0]            fetch_count
);

   typedef enum logic {
      ST_FETCH  = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t                 state_reg,     state_next;
   logic [ADDR_WIDTH-1:0]  pc_reg,        pc_next;
   logic [INSTR_WIDTH-1:0] instr_out_reg, instr_out_next;
   logic [ADDR_WIDTH-1:0]  instr_pc_reg,  instr_pc_next;
   logic                   valid_reg,     valid_next;
   logic [15:0]            count_reg,     count_next;

   // Handshake terms: the presented instruction is consumed this cycle, and
   // the output register may be overwritten this cycle.
   logic                   accepted;
   logic                   out_free;
   logic [ADDR_WIDTH-1:0]  target_aligned;

   assign accepted       = valid_reg & instr_ready;
   assign out_free       = ~valid_reg | instr_ready;
   assign target_aligned = {jump_target[ADDR_WIDTH-1:1], 1'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_FETCH;
         pc_reg        <= RESET_PC;
         instr_out_reg <= '0;
         instr_pc_reg  <= '0;
         valid_reg     <= 1'b0;
         count_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         instr_out_reg <= instr_out_next;
         instr_pc_reg  <= instr_pc_next;
         valid_reg     <= valid_next;
         count_reg     <= count_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      instr_out_next = instr_out_reg;
      instr_pc_next  = instr_pc_reg;
      valid_next     = valid_reg;
      count_next     = count_reg;

      unique case (state_reg)
         ST_FETCH: begin
            if (jump_valid) begin
               // Redirect flushes whatever is presented, even if decode is
               // taking it this cycle; a same-cycle halt still takes effect.
               pc_next    = target_aligned;
               valid_next = 1'b0;
               state_next = halt ? ST_HALTED : ST_FETCH;
            end else if (halt) begin
               if (accepted) begin
                  valid_next = 1'b0;
               end
               state_next = ST_HALTED;
            end else if (out_free) begin
               instr_out_next = mem_instr;
               instr_pc_next  = pc_reg;
               valid_next     = 1'b1;
               pc_next        = pc_reg + ADDR_WIDTH'(PC_STEP);
               if (count_reg != 16'hFFFF) begin
                  count_next = count_reg + 16'd1;
               end
            end
            // otherwise stalled: everything holds
         end

         ST_HALTED: begin
            if (jump_valid) begin
               pc_next    = target_aligned;
               valid_next = 1'b0;
               state_next = ST_FETCH;
            end else if (accepted) begin
               // Drain the last instruction captured before the halt.
               valid_next = 1'b0;
            end
         end

         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   assign pc_address  = pc_reg;
   assign instr_out   = instr_out_reg;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = valid_reg;
   assign halted      = (state_reg == ST_HALTED);
   assign fetch_count = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pc_address;
   logic [7:0] mem_instr;
   logic [7:0] instr_out;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       jump_valid;
   logic [7:0] jump_target;
   logic       halt;
   logic       halted;
   logic [15:0] fetch_count;

   logic [7:0] mem [0:255];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instruction memory: combinational read.
   assign mem_instr = mem[pc_address];

   instruction_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .pc_address  (pc_address),
      .mem_instr   (mem_instr),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .halt        (halt),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_program();
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[8'h00] = 8'h00; mem[8'h02] = 8'hD3; mem[8'h04] = 8'h50;
      mem[8'h06] = 8'hD1; mem[8'h08] = 8'h51; mem[8'h0A] = 8'h10;
   endtask

   task automatic do_reset();
      reset = 1'b1; instr_ready = 1'b1; jump_valid = 1'b0;
      jump_target = 8'h00; halt = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; instr_ready = 1'b1; jump_valid = 1'b1;
      jump_target = 8'h40; halt = 1'b1;
      step();
      checks++; if (pc_address !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc_address); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
      checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      checks++; if ({instr_out, instr_pc} !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h/%h exp=00/00", instr_out, instr_pc); end
      reset = 1'b0; jump_valid = 1'b0; halt = 1'b0;
   endtask

   task automatic test_sequential();
      logic [7:0] exp_seq [6];
      exp_seq = '{8'h00, 8'hD3, 8'h50, 8'hD1, 8'h51, 8'h10};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (instr_valid !== 1'b1 || instr_out !== exp_seq[i] || instr_pc !== 8'(2*i)) begin
            failures++;
            $display("FAIL seq[%0d] got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr_out, instr_pc, exp_seq[i], 8'(2*i));
         end
      end
      checks++; if (fetch_count !== 16'd6) begin failures++; $display("FAIL seq_count got=%0d exp=6", fetch_count); end
      checks++; if (pc_address !== 8'h0C) begin failures++; $display("FAIL seq_pc got=%h exp=0C", pc_address); end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(); step();   // 00@00 then D3@02
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (instr_valid !== 1'b1 || instr_out !== 8'hD3 || instr_pc !== 8'h02 || pc_address !== 8'h04) begin
            failures++;
            $display("FAIL stall[%0d] got=%b/%h/%h/%h exp=1/D3/02/04", i, instr_valid, instr_out, instr_pc, pc_address);
         end
      end
      instr_ready = 1'b1;
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 8'h50 || instr_pc !== 8'h04) begin
         failures++;
         $display("FAIL stall_release got=%b/%h/%h exp=1/50/04", instr_valid, instr_out, instr_pc);
      end
   endtask

   task automatic test_jump();
      do_reset();
      step(); step(); step();   // instr_pc = 04
      jump_valid = 1'b1; jump_target = 8'h09;
      step();
      jump_valid = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || pc_address !== 8'h08) begin
         failures++; $display("FAIL jump_bubble got=%b/%h exp=0/08", instr_valid, pc_address);
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 8'h51 || instr_pc !== 8'h08) begin
         failures++; $display("FAIL jump_first got=%b/%h/%h exp=1/51/08", instr_valid, instr_out, instr_pc);
      end
      step();
      checks++;
      if (instr_out !== 8'h10 || instr_pc !== 8'h0A) begin
         failures++; $display("FAIL jump_second got=%h/%h exp=10/0A", instr_out, instr_pc);
      end
   endtask

   task automatic test_halt_resume();
      do_reset();
      step(); step(); step();   // 50@04 presented, pc_address = 06
      halt = 1'b1; instr_ready = 1'b0;
      step();
      halt = 1'b0;
      checks++;
      if (halted !== 1'b1 || pc_address !== 8'h06 || instr_valid !== 1'b1 || instr_out !== 8'h50) begin
         failures++; $display("FAIL halt_enter got=%b/%h/%b/%h exp=1/06/1/50", halted, pc_address, instr_valid, instr_out);
      end
      step();
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b1 || pc_address !== 8'h06) begin
         failures++; $display("FAIL halt_hold got=%b/%b/%h exp=1/1/06", halted, instr_valid, pc_address);
      end
      instr_ready = 1'b1;
      step();
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || pc_address !== 8'h06) begin
         failures++; $display("FAIL halt_drain got=%b/%b/%h exp=1/0/06", halted, instr_valid, pc_address);
      end
      step();
      checks++;
      if (instr_valid !== 1'b0 || pc_address !== 8'h06 || fetch_count !== 16'd3) begin
         failures++; $display("FAIL halt_frozen got=%b/%h/%0d exp=0/06/3", instr_valid, pc_address, fetch_count);
      end
      jump_valid = 1'b1; jump_target = 8'h00;
      step();
      jump_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || instr_valid !== 1'b0 || pc_address !== 8'h00) begin
         failures++; $display("FAIL resume_jump got=%b/%b/%h exp=0/0/00", halted, instr_valid, pc_address);
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 8'h00 || instr_pc !== 8'h00) begin
         failures++; $display("FAIL resume_fetch got=%b/%h/%h exp=1/00/00", instr_valid, instr_out, instr_pc);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] fe_val;
      fe_val = 8'($urandom);
      mem[8'hFE] = fe_val;
      do_reset();
      jump_valid = 1'b1; jump_target = 8'hFE;
      step();
      jump_valid = 1'b0;
      checks++; if (pc_address !== 8'hFE) begin failures++; $display("FAIL wrap_jump got=%h exp=FE", pc_address); end
      step();
      checks++;
      if (instr_out !== fe_val || instr_pc !== 8'hFE || pc_address !== 8'h00) begin
         failures++; $display("FAIL wrap_fe got=%h/%h/%h exp=%h/FE/00", instr_out, instr_pc, pc_address, fe_val);
      end
      step();
      checks++;
      if (instr_out !== 8'h00 || instr_pc !== 8'h00 || pc_address !== 8'h02) begin
         failures++; $display("FAIL wrap_00 got=%h/%h/%h exp=00/00/02", instr_out, instr_pc, pc_address);
      end
   endtask

   task automatic test_simultaneous_reset();
      do_reset();
      step();   // 00@00 presented
      jump_valid = 1'b1; halt = 1'b1; jump_target = 8'h0A;
      step();
      jump_valid = 1'b0; halt = 1'b0;
      checks++;
      if (halted !== 1'b1 || pc_address !== 8'h0A || instr_valid !== 1'b0) begin
         failures++; $display("FAIL jump_halt got=%b/%h/%b exp=1/0A/0", halted, pc_address, instr_valid);
      end
      jump_valid = 1'b1; jump_target = 8'h00;
      step();
      jump_valid = 1'b0;
      step();   // 00@00 captured
      instr_ready = 1'b0;
      step();   // stalled
      checks++;
      if (instr_valid !== 1'b1 || fetch_count !== 16'd2 || pc_address !== 8'h02) begin
         failures++; $display("FAIL pre_reset_stall got=%b/%0d/%h exp=1/2/02", instr_valid, fetch_count, pc_address);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (pc_address !== 8'h00 || instr_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
         failures++; $display("FAIL mid_stall_reset got=%h/%b/%b/%0d exp=00/0/0/0", pc_address, instr_valid, halted, fetch_count);
      end
   endtask

   // Randomized ready/jump traffic against a transaction-level model: the
   // stream of captured addresses is sequential by 2 and restarts at each
   // (aligned) jump target; each capture carries mem[address]; a held
   // instruction never changes.
   task automatic test_random();
      logic [7:0]  next_cap;
      logic [15:0] model_count;
      logic        pre_valid;
      logic [7:0]  pre_out, pre_pc, tgt;
      logic        free;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      do_reset();
      next_cap    = 8'h00;
      model_count = 16'd0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         pre_valid   = instr_valid;
         pre_out     = instr_out;
         pre_pc      = instr_pc;
         instr_ready = ($urandom_range(0, 3) != 0);
         jump_valid  = ($urandom_range(0, 9) == 0);
         jump_target = 8'($urandom);
         tgt         = jump_target & 8'hFE;
         free        = !pre_valid || instr_ready;
         step();
         if (jump_valid) begin
            checks++;
            if (instr_valid !== 1'b0 || pc_address !== tgt) begin
               failures++; $display("FAIL rnd_jump[%0d] got=%b/%h exp=0/%h", cyc, instr_valid, pc_address, tgt);
            end
            next_cap = tgt;
         end else if (free) begin
            model_count++;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== next_cap || instr_out !== mem[next_cap] || fetch_count !== model_count) begin
               failures++;
               $display("FAIL rnd_capture[%0d] got=%b/%h/%h/%0d exp=1/%h/%h/%0d", cyc, instr_valid, instr_pc, instr_out, fetch_count, next_cap, mem[next_cap], model_count);
            end
            next_cap = next_cap + 8'd2;
            checks++;
            if (pc_address !== next_cap) begin
               failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", cyc, pc_address, next_cap);
            end
         end else begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== pre_out || instr_pc !== pre_pc || pc_address !== next_cap) begin
               failures++; $display("FAIL rnd_stall[%0d] got=%b/%h/%h/%h exp=1/%h/%h/%h", cyc, instr_valid, instr_out, instr_pc, pc_address, pre_out, pre_pc, next_cap);
            end
         end
      end
      jump_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; instr_ready = 1'b0; jump_valid = 1'b0;
      jump_target = 8'h00; halt = 1'b0;
      load_program();
      test_reset();
      test_sequential();
      test_backpressure();
      test_jump();
      test_halt_resume();
      test_wrap();
      test_simultaneous_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
